cbus_ram_responder: RTL
=======================

// Module: cbus_ram_responder
// PURPOSE
//  Responder end of the cbus: a behavioural word-addressed backing memory that serves cbus read/write
//  bursts (MLEN1..MLEN16) issued by the I/D caches. Sits behind the cbus arbiter in simulation/FPGA
//  test tops; replaces the external memory model so that cache refills and write-backs run on-chip.
// PARAMETERS
//  DEPTH_WORDS   4096     memory depth in 32-bit words (power of two)
//  FIRST_LATENCY 2        idle cycles between request capture and the first ready beat (0..15)
//  STALL_SEED    16'hACE1 LFSR seed for random stalls (used only with CBUS_RAM_STALL_EN)
// PORTS
//  clk     in   1                 clock; all state updates on posedge
//  resetn  in   1                 reset, asynchronous, active-low
//  creq    in   cbus_req_t        request: valid, is_write, size, addr, strobe, data, len
//  cresp   out  cbus_resp_t       response: ready, last, data
//  busy    out  1                 high while a burst is captured (state != CR_IDLE)
// BEHAVIOUR
//  - Reset (async assert): state CR_IDLE, beat counter 0, latency counter 0, cresp='0, busy=0.
//    Memory contents are NOT reset. Deassertion of resetn is synchronised by the top.
//  - FSM states: CR_IDLE, CR_WAIT, CR_BURST.
//  - CR_IDLE: creq.valid=1 -> latch addr, len, is_write; beat=0; go CR_WAIT (lat=FIRST_LATENCY),
//    or straight to CR_BURST if FIRST_LATENCY==0. cresp='0 in this state. First ready >= 1 cycle after valid.
//  - CR_WAIT: count lat down; at lat==1 go CR_BURST. cresp='0.
//  - CR_BURST: beats = len+1 (cbus_len_t encodes beats-1). Word index = (base_addr[31:2] + beat) mod DEPTH_WORDS.
//    Incrementing burst; no wrap at burst boundary; out-of-range addresses alias modulo depth.
//    Beat cycle: ready=1; data = mem[index] (combinational read, pre-write value);
//    last = (beat==len). Write: on ready & is_write, mem[index] <= per-byte merge of creq.data by creq.strobe.
//    size is ignored for reads (full word returned); writes rely on strobe only.
//    After the last beat -> CR_IDLE, beat=0. A new request is sampled no earlier than the next cycle.
//  - Initiator holds creq.valid and request fields stable for the whole burst; write data advances per ready.
//  - creq.valid dropping in CR_WAIT/CR_BURST: abort, return to CR_IDLE next cycle, no further beats/writes;
//    ready=0 in the cycle valid is low.
//  - Reset asserted mid-burst: outputs zero immediately; partially written burst words remain written.
//  - busy = (state != CR_IDLE); cresp.data = '0 whenever ready=0.
// CONFIGURATION
//  CBUS_RAM_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seeded STALL_SEED on reset) advances
//   every cycle; in CR_BURST ready is withheld (beat not counted, no write) when lfsr[1:0]==2'b00.
//   Exercises caches under back-pressure.
//  Not defined: no LFSR logic; ready asserted on every CR_BURST cycle (one beat per cycle).
// STRUCTURE
//  - Shared package: cbus_ram_state_t enum {CR_IDLE, CR_WAIT, CR_BURST}; CBUS_RAM_STALL_TAPS constant.
//    cbus_req_t, cbus_resp_t, cbus_len_t, MLEN*/MSIZE* already live in the common header.
//  - One sub-module: lfsr16 (clk, resetn, seed, en, q[15:0]), instantiated only under CBUS_RAM_STALL_EN.
//  - Memory is a flop/distributed array in this module; byte-merge is a local function.
// TESTING
//  1 Reset: resetn=0 mid-burst -> cresp=='0, busy==0 same cycle; after release idle with valid=0 -> no ready.
//  2 Preload mem[0x10..0x1F]=0x1000+i; read addr 0x40 len=MLEN16, FIRST_LATENCY=2 -> first ready 3 cycles
//    after valid, 16 consecutive beats data 0x1000..0x100F, last only on beat 15.
//  3 Write addr 0x80 MLEN4 data A0..A3 strobe 4'b1111, then read MLEN4 -> A0..A3; single write data
//    0xDEADBEEF strobe 4'b0011 over 0x11223344 -> reads 0x1122BEEF.
//  4 Abort: valid dropped after beat 5 of a 16-beat write -> only words 0..5 modified; next read at 0 OK.
//  5 Alias: read addr = DEPTH_WORDS*4 + 0x8, MLEN1 -> returns mem[2]; burst crossing top word wraps to 0.
//  6 With CBUS_RAM_STALL_EN: MLEN16 read -> exactly 16 ready beats, data in order, gaps where lfsr[1:0]==0.

Source files
------------

// File: rtl/cbus_ram_responder_pkg.sv
// Shared types for the cbus RAM responder.
//  - cbus request/response structs, burst length and size encodings
//  - cbus_ram_state_t: responder FSM states
//  - CBUS_RAM_STALL_TAPS: feedback mask of the stall LFSR (taps 16,14,13,11)
package cbus_ram_responder_pkg;

    // Burst length is encoded as beats-1.
    typedef logic [3:0] cbus_len_t;
    localparam cbus_len_t MLEN1  = 4'd0;
    localparam cbus_len_t MLEN2  = 4'd1;
    localparam cbus_len_t MLEN4  = 4'd3;
    localparam cbus_len_t MLEN8  = 4'd7;
    localparam cbus_len_t MLEN16 = 4'd15;

    typedef logic [1:0] cbus_size_t;
    localparam cbus_size_t MSIZE1 = 2'd0;
    localparam cbus_size_t MSIZE2 = 2'd1;
    localparam cbus_size_t MSIZE4 = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        cbus_size_t  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        CR_IDLE  = 2'd0,
        CR_WAIT  = 2'd1,
        CR_BURST = 2'd2
    } cbus_ram_state_t;

    // Bits 15,13,12,10 of the shift register feed the XOR (taps 16,14,13,11).
    localparam logic [15:0] CBUS_RAM_STALL_TAPS = 16'hB400;

endpackage

// File: rtl/cbus_ram_responder_if.sv
// cbus link between an initiator (master) and the RAM responder (slave).
//  creq  : request from the initiator
//  cresp : response from the responder
interface cbus_ram_responder_if;
    import cbus_ram_responder_pkg::*;

    cbus_req_t  creq;
    cbus_resp_t cresp;

    modport master (output creq, input cresp);
    modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_ram_responder_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random back-pressure.
//  clk, resetn : clock, async active-low reset (loads seed)
//  seed        : reset value
//  en          : advance one step this cycle
//  q           : current register contents
module lfsr16
    import cbus_ram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next-state: shift left, feedback is the XOR of the tapped bits.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[14:0], ^(q_q & CBUS_RAM_STALL_TAPS)};
        end else begin
            q_d = q_q;
        end
    end

    // Shift register with async reset to the seed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cbus_ram_responder.sv
// cbus RAM responder: word-addressed backing memory serving cbus read/write
// bursts of 1..16 beats. Memory contents are not reset.
//  clk    : clock
//  resetn : async active-low reset
//  bus    : cbus slave port (creq in, cresp out)
//  busy   : high while a burst is captured
// Optional feature: define CBUS_RAM_STALL_EN to insert LFSR-driven stall
// cycles during bursts (ready withheld when lfsr[1:0]==2'b00).
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS   = 4096,
    parameter int          FIRST_LATENCY = 2,
    parameter logic [15:0] STALL_SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       resetn,
    cbus_ram_responder_if.slave        bus,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    cbus_ram_state_t state_q, state_d;
    cbus_len_t       beat_q, beat_d;
    cbus_len_t       len_q, len_d;
    logic [3:0]      lat_q, lat_d;
    logic [AW-1:0]   base_q, base_d;
    logic            wr_q, wr_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [AW-1:0]   idx_s;
    logic [31:0]     rdata_s;
    logic            stall_s;
    logic            ready_s;
    cbus_resp_t      resp_s;

    // Per-byte merge of new write data over the old word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

`ifdef CBUS_RAM_STALL_EN
    logic [15:0] lfsr_s;
    logic        unused_lfsr_s;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .seed   (STALL_SEED),
        .en     (1'b1),
        .q      (lfsr_s)
    );

    assign stall_s       = (lfsr_s[1:0] == 2'b00);
    assign unused_lfsr_s = ^lfsr_s[15:2];
`else
    logic unused_seed_s;

    assign stall_s       = 1'b0;
    assign unused_seed_s = ^STALL_SEED;
`endif

    // Size and sub-word/upper address bits play no part: full words, modulo depth.
    logic unused_req_s;
    assign unused_req_s = ^{bus.creq.size, bus.creq.addr[1:0], bus.creq.addr[31:AW+2]};

    // Word index wraps modulo depth by truncation to AW bits.
    assign idx_s   = base_q + AW'(beat_q);
    assign rdata_s = mem[idx_s];
    // Dropping valid aborts immediately: no beat in that cycle.
    assign ready_s = (state_q == CR_BURST) && bus.creq.valid && !stall_s;

    // FSM next-state: capture, latency countdown, beat counting, abort on valid drop.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        len_d   = len_q;
        lat_d   = lat_q;
        base_d  = base_q;
        wr_d    = wr_q;
        case (state_q)
            CR_IDLE: begin
                if (bus.creq.valid) begin
                    base_d = bus.creq.addr[AW+1:2];
                    len_d  = bus.creq.len;
                    wr_d   = bus.creq.is_write;
                    beat_d = 4'd0;
                    if (FIRST_LATENCY == 0) begin
                        state_d = CR_BURST;
                        lat_d   = 4'd0;
                    end else begin
                        state_d = CR_WAIT;
                        lat_d   = 4'(FIRST_LATENCY);
                    end
                end else begin
                    state_d = CR_IDLE;
                end
            end
            CR_WAIT: begin
                if (!bus.creq.valid) begin
                    state_d = CR_IDLE;
                    lat_d   = 4'd0;
                    beat_d  = 4'd0;
                end else if (lat_q <= 4'd1) begin
                    state_d = CR_BURST;
                    lat_d   = 4'd0;
                end else begin
                    lat_d   = lat_q - 4'd1;
                end
            end
            CR_BURST: begin
                if (!bus.creq.valid) begin
                    state_d = CR_IDLE;
                    beat_d  = 4'd0;
                end else if (ready_s) begin
                    if (beat_q == len_q) begin
                        state_d = CR_IDLE;
                        beat_d  = 4'd0;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = CR_IDLE;
                beat_d  = 4'd0;
                lat_d   = 4'd0;
            end
        endcase
    end

    // Response: all-zero unless a beat is being delivered this cycle.
    always_comb begin
        resp_s = '0;
        if (ready_s) begin
            resp_s.ready = 1'b1;
            resp_s.last  = (beat_q == len_q);
            resp_s.data  = rdata_s;
        end else begin
            resp_s = '0;
        end
    end

    // FSM and burst-context registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CR_IDLE;
            beat_q  <= 4'd0;
            len_q   <= 4'd0;
            lat_q   <= 4'd0;
            base_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            lat_q   <= lat_d;
            base_q  <= base_d;
            wr_q    <= wr_d;
        end
    end

    // Memory write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (ready_s && wr_q) begin
            mem[idx_s] <= byte_merge(rdata_s, bus.creq.data, bus.creq.strobe);
        end
    end

    assign bus.cresp = resp_s;
    assign busy      = (state_q != CR_IDLE);

endmodule
